// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch front-end: opcodes, immediate
// extraction and the fetch FSM state type.
package rv32_pkg;

    localparam logic [6:0] RV32_OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] RV32_OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} in instr[31:12]
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // B-type immediate: imm[12|10:5] in instr[31:25], imm[4:1|11] in instr[11:7]
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/rv32_branch_predictor.sv
// Static predictor: JAL and backward conditional branches are taken,
// everything else (including JALR) falls through to pc+4.
module rv32_branch_predictor
    import rv32_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        taken,
    output logic [31:0] next_pc
);

    // Decode the opcode and pick the predicted target; adds wrap modulo 2^32.
    always_comb begin
        taken   = 1'b0;
        next_pc = pc + 32'd4;
        if (instr[6:0] == RV32_OPCODE_JAL) begin
            taken   = 1'b1;
            next_pc = pc + imm_j(instr);
        end else if (instr[6:0] == RV32_OPCODE_BRANCH && instr[31]) begin
            taken   = 1'b1;
            next_pc = pc + imm_b(instr);
        end
    end

endmodule

// File: rtl/rv32_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction bus and
// presents registered {pc, instr, prediction} to decode.
//
// state | meaning
// FETCH | read to pc outstanding; deliver word when bus and decode allow
// DRAIN | read to a stale (pre-redirect) address outstanding; discard word
// HOLD  | word captured while decode stalled; no read until it is delivered
module rv32_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] instr_address_out,
    output logic        instr_read_out,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_read_value_in,
    output logic        valid_out,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [31:0] next_pc_out
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drain_pc;
    logic [31:0]  hold_pc;
    logic [31:0]  hold_instr;
    logic         hold_taken;
    logic [31:0]  hold_next_pc;

    logic         pred_taken;
    logic [31:0]  pred_next_pc;

    rv32_branch_predictor u_predictor (
        .pc      (pc),
        .instr   (instr_read_value_in),
        .taken   (pred_taken),
        .next_pc (pred_next_pc)
    );

    // The stale address must stay on the bus until the abandoned read completes.
    assign instr_address_out = (state == DRAIN) ? drain_pc : pc;
    assign instr_read_out    = (state != HOLD);

    // Fetch FSM: redirect beats everything but reset; leaving HOLD on a
    // redirect is what invalidates the hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= FETCH;
            pc                         <= RESET_VECTOR;
            drain_pc                   <= '0;
            hold_pc                    <= '0;
            hold_instr                 <= '0;
            hold_taken                 <= 1'b0;
            hold_next_pc               <= '0;
            valid_out                  <= 1'b0;
            branch_predicted_taken_out <= 1'b0;
            pc_out                     <= '0;
            instr_out                  <= '0;
            next_pc_out                <= '0;
        end else if (redirect_in) begin
            pc <= redirect_pc_in;
            if (!stall_in) begin
                valid_out <= 1'b0;
            end
            case (state)
                FETCH: begin
                    if (!instr_ready_in) begin
                        drain_pc <= pc;
                        state    <= DRAIN;
                    end
                end
                DRAIN:   state <= DRAIN;
                HOLD:    state <= FETCH;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (instr_ready_in) begin
                        if (!stall_in) begin
                            valid_out                  <= 1'b1;
                            pc_out                     <= pc;
                            instr_out                  <= instr_read_value_in;
                            branch_predicted_taken_out <= pred_taken;
                            next_pc_out                <= pred_next_pc;
                            pc                         <= pred_next_pc;
                        end else begin
                            hold_pc      <= pc;
                            hold_instr   <= instr_read_value_in;
                            hold_taken   <= pred_taken;
                            hold_next_pc <= pred_next_pc;
                            state        <= HOLD;
                        end
                    end else if (!stall_in) begin
                        valid_out <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        valid_out                  <= 1'b1;
                        pc_out                     <= hold_pc;
                        instr_out                  <= hold_instr;
                        branch_predicted_taken_out <= hold_taken;
                        next_pc_out                <= hold_next_pc;
                        pc                         <= hold_next_pc;
                        state                      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (!stall_in) begin
                        valid_out <= 1'b0;
                    end
                    if (instr_ready_in) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_fetch.sv
// Scoreboard bench for rv32_fetch: the stimulus pushes hand-computed
// deliveries, a negedge monitor pops one per instruction decode accepts.
module tb_rv32_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic [31:0] instr_address_out;
    logic        instr_read_out;
    logic        instr_ready_in;
    logic [31:0] instr_read_value_in;
    logic        valid_out;
    logic        branch_predicted_taken_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [31:0] next_pc_out;

    logic        ready_en;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    rv32_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .stall_in                   (stall_in),
        .redirect_in                (redirect_in),
        .redirect_pc_in             (redirect_pc_in),
        .instr_address_out          (instr_address_out),
        .instr_read_out             (instr_read_out),
        .instr_ready_in             (instr_ready_in),
        .instr_read_value_in        (instr_read_value_in),
        .valid_out                  (valid_out),
        .branch_predicted_taken_out (branch_predicted_taken_out),
        .pc_out                     (pc_out),
        .instr_out                  (instr_out),
        .next_pc_out                (next_pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hFE00_0EE3; // beq x0,x0,-4
            32'h50:  return 32'h0080_006F; // jal x0,+8
            32'h58:  return 32'h0000_0463; // beq x0,x0,+8 (forward)
            32'h5C:  return 32'h0000_8067; // jalr x0,0(x1)
            default: return NOP;
        endcase
    endfunction

    assign instr_read_value_in = mem_word(instr_address_out);
    assign instr_ready_in      = ready_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] w,
                            input logic t, input logic [31:0] n);
        exp_t e;
        e.pc = p; e.instr = w; e.taken = t; e.npc = n;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: decode accepts an instruction on each unstalled cycle with valid_out.
    always @(negedge clk) begin
        if (!reset && valid_out && !stall_in) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h, expected no delivery", pc_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc",      pc_out,                     mon_e.pc);
                check("out_instr",   instr_out,                  mon_e.instr);
                check("out_taken",   branch_predicted_taken_out, {31'd0, mon_e.taken});
                check("out_next_pc", next_pc_out,                mon_e.npc);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        stall_in       = 1'b0;
        redirect_in    = 1'b0;
        redirect_pc_in = '0;
        ready_en       = 1'b0;
        step(2);

        check("rst_valid",   valid_out, 0);
        check("rst_taken",   branch_predicted_taken_out, 0);
        check("rst_pc_out",  pc_out, 0);
        check("rst_instr",   instr_out, 0);
        check("rst_next_pc", next_pc_out, 0);
        check("rst_addr",    instr_address_out, 32'h0);
        check("rst_read",    instr_read_out, 1);

        // Sequential NOPs then the backward branch at 0x10.
        reset    = 1'b0;
        ready_en = 1'b1;
        push_exp(32'h00, NOP, 1'b0, 32'h04);
        push_exp(32'h04, NOP, 1'b0, 32'h08);
        push_exp(32'h08, NOP, 1'b0, 32'h0C);
        push_exp(32'h0C, NOP, 1'b0, 32'h10);
        push_exp(32'h10, 32'hFE00_0EE3, 1'b1, 32'h0C);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", instr_address_out, 32'(4 * i));
            step(1);
            check("t1_valid", valid_out, 1);
        end
        check("t1_addr_10", instr_address_out, 32'h10);
        step(1);
        ready_en = 1'b0;
        check("t2_taken",   branch_predicted_taken_out, 1);
        check("t2_next_pc", next_pc_out, 32'h0C);
        check("t2_addr",    instr_address_out, 32'h0C);
        step(1);

        // Three wait states at 0x20.
        redirect_in = 1'b1; redirect_pc_in = 32'h20; ready_en = 1'b1;
        step(1);
        redirect_in = 1'b0; ready_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_addr_hold", instr_address_out, 32'h20);
            check("t3_read_hold", instr_read_out, 1);
            step(1);
            check("t3_bubble", valid_out, 0);
        end
        check("t3_addr_still", instr_address_out, 32'h20);
        push_exp(32'h20, NOP, 1'b0, 32'h24);
        ready_en = 1'b1;
        step(1);
        ready_en = 1'b0;
        check("t3_addr_next", instr_address_out, 32'h24);
        step(1);

        // Stall in the cycle 0x30's word returns.
        redirect_in = 1'b1; redirect_pc_in = 32'h2C; ready_en = 1'b1;
        step(1);
        redirect_in = 1'b0;
        push_exp(32'h2C, NOP, 1'b0, 32'h30);
        step(1);
        stall_in = 1'b1;
        step(1);
        check("t4_read_stalled", instr_read_out, 0);
        check("t4_frozen_pc",    pc_out, 32'h2C);
        check("t4_frozen_valid", valid_out, 1);
        step(1);
        check("t4_read_stalled2", instr_read_out, 0);
        check("t4_frozen_pc2",    pc_out, 32'h2C);
        push_exp(32'h30, NOP, 1'b0, 32'h34);
        stall_in = 1'b0; ready_en = 1'b0;
        step(1);
        check("t4_release_pc", pc_out, 32'h30);
        check("t4_next_addr",  instr_address_out, 32'h34);
        check("t4_next_read",  instr_read_out, 1);
        step(1);
        check("t4_once", valid_out, 0);

        // Redirect to 0x100 while the read to 0x40 is outstanding.
        redirect_in = 1'b1; redirect_pc_in = 32'h40; ready_en = 1'b1;
        step(1);
        redirect_pc_in = 32'h100; ready_en = 1'b0;
        step(1);
        redirect_in = 1'b0;
        check("t5_drain_addr", instr_address_out, 32'h40);
        check("t5_drain_read", instr_read_out, 1);
        step(1);
        check("t5_drain_addr2", instr_address_out, 32'h40);
        check("t5_drain_valid", valid_out, 0);
        push_exp(32'h100, NOP, 1'b0, 32'h104);
        ready_en = 1'b1;
        step(1);
        check("t5_target_addr", instr_address_out, 32'h100);
        check("t5_discarded",   valid_out, 0);
        step(1);
        ready_en = 1'b0;
        check("t5_after_addr", instr_address_out, 32'h104);
        step(1);

        // JAL, forward branch and JALR predictions.
        redirect_in = 1'b1; redirect_pc_in = 32'h50; ready_en = 1'b1;
        step(1);
        redirect_in = 1'b0;
        push_exp(32'h50, 32'h0080_006F, 1'b1, 32'h58);
        push_exp(32'h58, 32'h0000_0463, 1'b0, 32'h5C);
        push_exp(32'h5C, 32'h0000_8067, 1'b0, 32'h60);
        step(3);
        ready_en = 1'b0;
        check("t7_addr", instr_address_out, 32'h60);
        step(1);

        // Reset asserted mid-DRAIN.
        redirect_in = 1'b1; redirect_pc_in = 32'h200;
        step(1);
        redirect_in = 1'b0;
        check("t6_drain_addr", instr_address_out, 32'h60);
        reset = 1'b1;
        step(1);
        check("t6_rst_addr",  instr_address_out, 32'h0);
        check("t6_rst_valid", valid_out, 0);
        check("t6_rst_read",  instr_read_out, 1);
        reset = 1'b0;
        push_exp(32'h00, NOP, 1'b0, 32'h04);
        ready_en = 1'b1;
        step(1);
        ready_en = 1'b0;
        check("t6_fetch_valid", valid_out, 1);
        check("t6_fetch_addr",  instr_address_out, 32'h04);
        step(2);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
